bip_datapath_v2: RTL
====================

BIP_DATAPATH_V2 -- requirements
Module: bip_datapath_v2

Interface
REQ-001 SHALL have parameter NBITS_O, default 11: instruction operand width.
REQ-002 SHALL have parameter NBITS_D, default 16: data, accumulator and ALU width (NBITS_D >= NBITS_O, NBITS_D >= 4).
REQ-003 SHALL have port i_clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port i_SelA, input, 2 bits: accumulator source. 0 = i_OutData, 1 = extended operand, 2 = ALU result, 3 = hold.
REQ-006 SHALL have port i_SelB, input, 1 bit: ALU B operand. 0 = i_OutData, 1 = extended operand.
REQ-007 SHALL have port i_WrAcc, input, 1 bit: accumulator write strobe.
REQ-008 SHALL have port i_Op, input, 3 bits: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRA, 7 MUL.
REQ-009 SHALL have port i_ExtMode, input, 1 bit: operand extension. 0 = sign, 1 = zero.
REQ-010 SHALL have port i_Operand, input, NBITS_O bits: immediate operand.
REQ-011 SHALL have port i_OutData, input, NBITS_D bits: data-memory read value.
REQ-012 SHALL have port o_InData, output, NBITS_D bits: accumulator value (data-memory write value).
REQ-013 SHALL have port o_Flags, output, 4 bits: {Z,N,C,V}, registered.
REQ-014 SHALL have port o_busy, output, 1 bit: multiply in progress.
REQ-015 SHALL have port o_done, output, 1 bit: one-cycle pulse at multiply completion.

Function
REQ-016 The extended operand SHALL be i_Operand sign- or zero-extended to NBITS_D, per i_ExtMode; this path is combinational.
REQ-017 With i_WrAcc=1, o_busy=0, and (i_SelA!=2 or i_Op!=MUL), ACC SHALL load the selected source at the next edge; o_InData updates one cycle after the strobe.
REQ-018 i_SelA=3, or i_WrAcc=0, SHALL leave ACC and flags unchanged.
REQ-019 ALU ops SHALL be computed with A=ACC and B=SelB source:
- ADD: A+B.
- SUB: A-B.
- AND, OR, XOR: bitwise.
- SLL: A shifted left by B[3:0].
- SRA: A arithmetic-shifted right by B[3:0].
REQ-020 Flags SHALL update only on an ACC write with i_SelA=2:
- Z: result==0.
- N: result MSB.
- C for ADD: carry-out.
- C for SUB: no-borrow (A>=B unsigned).
- C for SLL/SRA: last bit shifted out, 0 when the shift amount is 0.
- V for ADD/SUB: signed overflow.
- C=V=0 for logic ops and MUL.
REQ-021 A MUL strobe SHALL latch A and B and start an iterative shift-add multiply.
- o_busy is high for exactly NBITS_D cycles, starting the cycle after the strobe.
REQ-022 On the final busy cycle's edge:
- ACC SHALL take the low NBITS_D bits of A*B.
- Z and N SHALL update.
- o_busy SHALL fall.
- o_done SHALL pulse high for one cycle, coincident with the new o_InData.
REQ-023 While o_busy=1, all i_WrAcc strobes SHALL be ignored (not queued); ACC keeps its pre-MUL value until completion.
REQ-024 The multiplier state machine SHALL have states IDLE -> RUN (counter 0..NBITS_D-1) -> IDLE.
- No other states.
- A strobe arriving in the o_done cycle is accepted normally.

Reset
REQ-025 i_reset=0 at an edge SHALL clear ACC, o_Flags, o_busy, o_done and the multiplier counter to 0, including mid-multiply (no o_done, result discarded).
REQ-026 Reset SHALL take priority over i_WrAcc in the same cycle.

Structure
REQ-027 Op codes, SelA codes and flag bit indices SHALL live in shared package bip_pkg, reused by the control unit.
REQ-028 The iterative multiplier SHALL be sub-module bip_mul_seq (start/busy/done handshake, NBITS_D parameter); extension, muxes and the single-cycle ALU stay in this module.

Verification (NBITS_D=16, NBITS_O=11)
REQ-029 Set ACC=0x1234, then hold i_reset=0 for 1 cycle -> o_InData=0, o_Flags=0, o_busy=0; a WrAcc in the same cycle is ignored.
REQ-030 Load i_Operand=0x7FB with SelA=1 -> ExtMode=0 gives ACC=0xFFFB; ExtMode=1 gives ACC=0x07FB; flags unchanged.
REQ-031 Arithmetic flag checks with SelA=2:
- ACC=0x7FFF, ADD imm 1 -> ACC=0x8000, flags Z0 N1 C0 V1.
- ACC=5, SUB mem 5 -> ACC=0, flags Z1 N0 C1 V0.
REQ-032 Shift checks with SelA=2:
- ACC=0x8001, SRA by 1 -> ACC=0xC000, C=1.
- ACC=0x8001, SLL by 0 -> ACC unchanged, C=0.
REQ-033 ACC=300, MUL imm 200:
- o_busy is high for 16 cycles; WrAcc strobes during busy have no effect.
- Then ACC=0xEA60, o_done pulses 1 cycle, flags Z0 N1 C0 V0.
REQ-034 Start MUL, then assert i_reset=0 at busy cycle 8 -> ACC=0, o_busy=0, o_done never pulses; the next ADD works normally.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared encodings for the BIP datapath and its control unit: opcodes,
// accumulator source selects, flag bit positions and multiplier states.
package bip_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRA = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        SELA_MEM  = 2'd0,
        SELA_IMM  = 2'd1,
        SELA_ALU  = 2'd2,
        SELA_HOLD = 2'd3
    } sel_a_e;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_e;

    localparam logic SELB_MEM = 1'b0;
    localparam logic SELB_IMM = 1'b1;
    localparam logic EXT_ZERO = 1'b1;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/bip_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle for NBITS_D
// cycles, returning the low NBITS_D bits of a*b.
module bip_mul_seq
    import bip_pkg::*;
#(
    parameter int NBITS_D = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NBITS_D-1:0] i_a,
    input  logic [NBITS_D-1:0] i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_finish,
    output logic [NBITS_D-1:0] o_product
);

    localparam int CW = $clog2(NBITS_D);
    localparam logic [CW-1:0] LAST = CW'(NBITS_D - 1);

    mul_state_e         state;
    mul_state_e         state_next;
    logic [CW-1:0]      cnt;
    logic [NBITS_D-1:0] a_sh;
    logic [NBITS_D-1:0] b_sh;
    logic [NBITS_D-1:0] prod;
    logic [NBITS_D-1:0] prod_next;
    logic               done_q;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state <= MUL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o_busy     = 1'b0;
        o_finish   = 1'b0;
        case (state)
            MUL_IDLE: begin
                if (i_start) begin
                    state_next = MUL_RUN;
                end
            end
            MUL_RUN: begin
                o_busy = 1'b1;
                if (cnt == LAST) begin
                    o_finish   = 1'b1;
                    state_next = MUL_IDLE;
                end
            end
            default: state_next = MUL_IDLE;
        endcase
    end

    // The final partial product is exposed combinationally so the caller can
    // capture the result on the same edge that ends the busy window.
    always_comb begin
        prod_next = prod + (b_sh[0] ? a_sh : '0);
        o_product = prod_next;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            prod   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= o_finish;
            if (state == MUL_IDLE && i_start) begin
                cnt  <= '0;
                a_sh <= i_a;
                b_sh <= i_b;
                prod <= '0;
            end else if (state == MUL_RUN) begin
                prod <= prod_next;
                a_sh <= a_sh << 1;
                b_sh <= b_sh >> 1;
                cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
            end
        end
    end

    assign o_done = done_q;

endmodule

// File: rtl/bip_datapath_v2.sv
// BIP accumulator datapath: operand extension, source muxes, single-cycle
// ALU with registered flags, and an attached iterative multiplier.
module bip_datapath_v2
    import bip_pkg::*;
#(
    parameter int NBITS_O = 11,
    parameter int NBITS_D = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [1:0]         i_SelA,
    input  logic               i_SelB,
    input  logic               i_WrAcc,
    input  logic [2:0]         i_Op,
    input  logic               i_ExtMode,
    input  logic [NBITS_O-1:0] i_Operand,
    input  logic [NBITS_D-1:0] i_OutData,
    output logic [NBITS_D-1:0] o_InData,
    output logic [3:0]         o_Flags,
    output logic               o_busy,
    output logic               o_done
);

    localparam int MSB = NBITS_D - 1;

    op_e                sel_op;
    sel_a_e             sel_a;
    logic [NBITS_D-1:0] acc;
    logic [NBITS_D-1:0] acc_next;
    logic [3:0]         flags;
    logic [NBITS_D-1:0] ext_operand;
    logic [NBITS_D-1:0] alu_b;
    logic [NBITS_D-1:0] alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [3:0]         sh;
    logic [NBITS_D:0]   shl_w;
    logic [NBITS_D:0]   shr_w;
    logic               accept;
    logic               mul_start;
    logic               acc_load;
    logic               mul_busy;
    logic               mul_done;
    logic               mul_finish;
    logic [NBITS_D-1:0] mul_product;

    assign sel_op = op_e'(i_Op);
    assign sel_a  = sel_a_e'(i_SelA);

    always_comb begin
        if (i_ExtMode == EXT_ZERO) begin
            ext_operand = NBITS_D'(i_Operand);
        end else begin
            ext_operand = NBITS_D'($signed(i_Operand));
        end
        alu_b = (i_SelB == SELB_IMM) ? ext_operand : i_OutData;
    end

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        shl_w   = '0;
        shr_w   = '0;
        sh      = alu_b[3:0];
        case (sel_op)
            OP_ADD: begin
                {alu_c, alu_res} = {1'b0, acc} + {1'b0, alu_b};
                alu_v = (acc[MSB] == alu_b[MSB]) && (alu_res[MSB] != acc[MSB]);
            end
            OP_SUB: begin
                alu_res = acc - alu_b;
                alu_c   = (acc >= alu_b);
                alu_v   = (acc[MSB] != alu_b[MSB]) && (alu_res[MSB] != acc[MSB]);
            end
            OP_AND: alu_res = acc & alu_b;
            OP_OR:  alu_res = acc | alu_b;
            OP_XOR: alu_res = acc ^ alu_b;
            OP_SLL: begin
                shl_w   = {1'b0, acc} << sh;
                alu_res = shl_w[NBITS_D-1:0];
                alu_c   = shl_w[NBITS_D];
            end
            OP_SRA: begin
                // A guard bit below the LSB catches the last bit shifted out.
                shr_w   = $signed({acc, 1'b0}) >>> sh;
                alu_res = shr_w[NBITS_D:1];
                alu_c   = shr_w[0];
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        accept    = i_WrAcc && !mul_busy;
        mul_start = accept && (sel_a == SELA_ALU) && (sel_op == OP_MUL);
        acc_load  = accept && !mul_start && (sel_a != SELA_HOLD);
        case (sel_a)
            SELA_MEM: acc_next = i_OutData;
            SELA_IMM: acc_next = ext_operand;
            SELA_ALU: acc_next = alu_res;
            default:  acc_next = acc;
        endcase
    end

    bip_mul_seq #(
        .NBITS_D(NBITS_D)
    ) u_mul (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_start  (mul_start),
        .i_a      (acc),
        .i_b      (alu_b),
        .o_busy   (mul_busy),
        .o_done   (mul_done),
        .o_finish (mul_finish),
        .o_product(mul_product)
    );

    // acc_load is gated by !busy, so it never collides with mul_finish.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            acc   <= '0;
            flags <= '0;
        end else if (mul_finish) begin
            acc   <= mul_product;
            flags <= pack_flags(mul_product == '0, mul_product[MSB], 1'b0, 1'b0);
        end else if (acc_load) begin
            acc <= acc_next;
            if (sel_a == SELA_ALU) begin
                flags <= pack_flags(alu_res == '0, alu_res[MSB], alu_c, alu_v);
            end
        end
    end

    assign o_InData = acc;
    assign o_Flags  = flags;
    assign o_busy   = mul_busy;
    assign o_done   = mul_done;

endmodule
